mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-requester arbiter for the single shared memory/device bus (DataMemory plus memory-mapped peripherals).
- Requester 0 is the CPU MEM-stage data port; requester 1 is a secondary master (DMA/UART loader).
- Latches one request at a time, drives registered strobes to the slave, waits for slave ready (with timeout), then returns a one-cycle ack and read data. Exports a stall signal for the pipeline.

Parameters:
TIMEOUT, 15, max BUSY cycles waiting for mem_ready before abort; 0 disables timeout.
ADDR_W, 32, address width.
DATA_W, 32, data width.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 (CPU) transaction request
we0  input  1  requester 0: 1=write, 0=read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
ack0  output  1  requester 0 completion pulse
err0  output  1  requester 0 timeout flag, valid with ack0
rdata0  output  DATA_W  requester 0 read data, valid with ack0
stall0  output  1  req0 & ~ack0, combinational, freezes pipeline
req1, we1, addr1, wdata1, ack1, err1, rdata1  same as requester 0, for requester 1
mem_read  output  1  slave read strobe
mem_write  output  1  slave write strobe
mem_addr  output  ADDR_W  slave address
mem_wdata  output  DATA_W  slave write data
mem_rdata  input  DATA_W  slave read data, sampled when mem_ready=1
mem_ready  input  1  slave completion, sampled only in BUSY

Behaviour:
- States: IDLE, BUSY, DONE. Registers: state, owner (1 bit), last_grant (1 bit), cnt, latched we/addr/wdata, rdata_q, err_q.
- Reset: state=IDLE, last_grant=1, so requester 0 wins the first tie. cnt=0. All outputs 0: mem_read, mem_write, mem_addr, mem_wdata, ack*, err*, rdata*. stall0 follows its equation.
- IDLE:
  - One request asserted: grant it.
  - Both asserted: grant the one not equal to last_grant (round-robin).
  - On grant, latch the owner's we/addr/wdata, set owner and last_grant, cnt=0, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_read=~we_q, mem_write=we_q, mem_addr=addr_q, mem_wdata=wdata_q. All are registered and stable for the whole BUSY period.
  - mem_ready=1: capture mem_rdata into rdata_q (0 for writes), err_q=0, go to DONE.
  - Else, TIMEOUT!=0 and cnt==TIMEOUT-1: rdata_q=0, err_q=1, go to DONE.
  - Else: cnt++.
- DONE:
  - Strobes low.
  - ack of owner=1 for exactly this cycle; rdata/err of owner valid this cycle.
  - The non-owner's ack stays 0.
  - Next state IDLE.
- Latency: request seen in IDLE cycle N, mem_ready=1 in first BUSY cycle → BUSY at N+1, ack at N+2. Minimum 3 cycles per transaction; back-to-back grants start no sooner than N+3.
- rdataX holds its last value between acks. errX is 0 except in DONE of a timed-out transaction.
- Requester rule: hold req/we/addr/wdata stable until ack.
  - Dropping req after grant does not abort; the bus cycle completes and ack is still pulsed.
  - Changing addr after grant has no effect (latched).
- mem_ready while not in BUSY is ignored.
- Reset asserted in any state (including mid-BUSY): next edge gives IDLE with strobes low. No ack is produced for the aborted transaction, and last_grant returns to 1.
- Timeout counter width is clog2(TIMEOUT+1) and never wraps.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x10; slave ready in first BUSY cycle with mem_rdata=0xDEADBEEF → mem_read=1 at N+1, ack0=1 with rdata0=0xDEADBEEF at N+2, stall0=1 at N and N+1, 0 at N+2.
- Contention: req0 and req1 held continuously, slave always ready → grants alternate 0,1,0,1. ack0 at cycles 2 and 8, ack1 at cycles 5 and 11 (cycles counted from the first request). Never both acks in the same cycle.
- Write with wait states: req1=1, we1=1, addr1=0x4000000C, wdata1=0x5A; mem_ready held low for 3 BUSY cycles → mem_write=1 with stable addr/wdata for 4 cycles, then ack1=1, err1=0.
- Timeout: TIMEOUT=4, slave never ready → exactly 4 BUSY cycles, then ack0=1, err0=1, rdata0=0, then IDLE.
- Reset mid-BUSY: assert reset during the 2nd BUSY cycle → strobes 0 on the next edge, no ack. After release with both requests pending, requester 0 is granted first.
- Request dropped after grant: req1 pulsed for 1 cycle → transaction completes, ack1 pulses once, no second grant.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared memory/peripheral bus.
// One transaction in flight at a time; registered slave strobes, ready timeout, one-cycle ack.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_ack0,
  output logic              o_err0,
  output logic [DATA_W-1:0] o_rdata0,
  output logic              o_stall0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack1,
  output logic              o_err1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_stall1,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready
);

  // Width of 1 when the timeout is disabled so the counter stays a legal vector.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_last_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [DATA_W-1:0]   r_wdata_q;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_err0;
  logic                r_err1;
  logic                r_mem_read;
  logic                r_mem_write;

  state_t              w_state;
  logic                w_owner;
  logic                w_last_grant;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_we_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [DATA_W-1:0]   w_wdata_q;
  logic [DATA_W-1:0]   w_rdata0;
  logic [DATA_W-1:0]   w_rdata1;
  logic                w_ack0;
  logic                w_ack1;
  logic                w_err0;
  logic                w_err1;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_grant;
  logic                w_finish;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_cap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_we_q       <= 1'b0;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_last_grant <= w_last_grant;
      r_cnt        <= w_cnt;
      r_we_q       <= w_we_q;
      r_addr_q     <= w_addr_q;
      r_wdata_q    <= w_wdata_q;
      r_rdata0     <= w_rdata0;
      r_rdata1     <= w_rdata1;
      r_ack0       <= w_ack0;
      r_ack1       <= w_ack1;
      r_err0       <= w_err0;
      r_err1       <= w_err1;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_last_grant = r_last_grant;
    w_cnt        = r_cnt;
    w_we_q       = r_we_q;
    w_addr_q     = r_addr_q;
    w_wdata_q    = r_wdata_q;
    w_rdata0     = r_rdata0;
    w_rdata1     = r_rdata1;
    w_ack0       = 1'b0;
    w_ack1       = 1'b0;
    w_err0       = 1'b0;
    w_err1       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_grant      = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    w_cap        = '0;

    case (r_state)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          // Tie goes to whoever was not served last.
          w_grant      = (i_req0 && i_req1) ? ~r_last_grant : i_req1;
          w_owner      = w_grant;
          w_last_grant = w_grant;
          w_we_q       = w_grant ? i_we1    : i_we0;
          w_addr_q     = w_grant ? i_addr1  : i_addr0;
          w_wdata_q    = w_grant ? i_wdata1 : i_wdata0;
          w_cnt        = '0;
          w_mem_read   = ~w_we_q;
          w_mem_write  = w_we_q;
          w_state      = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (i_mem_ready) begin
          w_finish = 1'b1;
          w_cap    = r_we_q ? '0 : i_mem_rdata;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
        end else begin
          if (r_cnt != '1) w_cnt = r_cnt + CNT_W'(1);
          w_mem_read  = ~r_we_q;
          w_mem_write = r_we_q;
        end

        if (w_finish) begin
          w_state = ST_DONE;
          if (r_owner) begin
            w_ack1   = 1'b1;
            w_err1   = w_timeout;
            w_rdata1 = w_cap;
          end else begin
            w_ack0   = 1'b1;
            w_err0   = w_timeout;
            w_rdata0 = w_cap;
          end
        end
      end

      ST_DONE: begin
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_err0      = r_err0;
  assign o_err1      = r_err1;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
  assign o_stall0    = i_req0 & ~r_ack0;
  assign o_stall1    = i_req1 & ~r_ack1;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_addr_q;
  assign o_mem_wdata = r_wdata_q;

endmodule
